// File: rtl/axi_mem_slave_v2_pkg.sv
// ============================================================================
// Package : axi_mem_pkg
// Shared burst encodings, response codes and helpers for axi_mem_slave_v2.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package axi_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_t;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // WRAP is only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_mem_slave_v2_if.sv
// ============================================================================
// Interface : axi_mem_slave_v2_if
// AXI4 five-channel bus bundle with master and slave views.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface axi_mem_slave_v2_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64
) ();

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_mem_slave_v2_addr_gen.sv
// ============================================================================
// Module : axi_burst_addr_gen
// Per-beat AXI burst address sequencer (FIXED / INCR / WRAP).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int OB     = 6
) (
    input  wire logic              clk_core,
    input  wire logic              rst_n,
    input  wire logic              load,
    input  wire logic              advance,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [7:0]        len,
    input  wire logic [2:0]        size,
    input  wire logic [1:0]        burst,
    output logic [ADDR_W-1:0]      addr,
    output logic [7:0]             beat,
    output logic                   last
);

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    burst_t            r_burst;
    logic [7:0]        r_beat;

    logic [2:0]        w_size_clamp;
    burst_t            w_burst_eff;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_next;

    // Illegal WRAP lengths and the reserved encoding both degrade to INCR.
    always_comb begin
        w_size_clamp = (size > 3'(OB)) ? 3'(OB) : size;
        case (burst_t'(burst))
            FIXED:   w_burst_eff = FIXED;
            WRAP:    w_burst_eff = wrap_len_ok(len) ? WRAP : INCR;
            default: w_burst_eff = INCR;
        endcase
    end

    assign w_inc  = ADDR_W'(1) << r_size;
    assign w_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

    always_comb begin
        case (r_burst)
            FIXED:   w_next = r_addr;
            WRAP:    w_next = (r_addr & ~w_mask) | ((r_addr + w_inc) & w_mask);
            default: w_next = r_addr + w_inc;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= FIXED;
            r_beat  <= '0;
        end else if (load) begin
            r_addr  <= start_addr;
            r_len   <= len;
            r_size  <= w_size_clamp;
            r_burst <= w_burst_eff;
            r_beat  <= '0;
        end else if (advance) begin
            r_addr  <= w_next;
            r_beat  <= r_beat + 8'd1;
        end
    end

    assign addr = r_addr;
    assign beat = r_beat;
    assign last = (r_beat == r_len);

endmodule

`default_nettype wire

// File: rtl/axi_mem_slave_v2.sv
// ============================================================================
// Module : axi_mem_slave_v2
// Parametrised AXI4 slave memory model with DECERR and WLAST checking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_mem_slave_v2
    import axi_mem_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int ID_W       = 16,
    parameter int ADDR_W     = 64,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 2
) (
    input  wire logic         clk_core,
    input  wire logic         rst_n,
    axi_mem_slave_v2_if.slave axi,
    output logic [15:0]       wlast_err_cnt
);

    localparam int OB     = $clog2(DATA_W / 8);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int STRB_W = DATA_W / 8;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // Contents survive reset; only elaboration clears them.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [1:0]            r_w_state, w_w_next;
    logic                  r_awready;
    logic [ID_W-1:0]       r_wid;
    logic                  r_w_decerr, r_w_slverr;
    logic [15:0]           r_wlast_err_cnt;

    logic [1:0]            r_r_state, w_r_next;
    logic                  r_arready;
    logic [ID_W-1:0]       r_rid;
    logic [LAT_W-1:0]      r_lat_cnt;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic [ADDR_W-1:0]     w_waddr, w_raddr;
    logic [7:0]            w_wbeat, w_rbeat;
    logic                  w_wlast_beat, w_rlast_beat;
    logic                  w_w_oor, w_r_oor, w_wlast_err;
    logic [DEPTH_LOG2-1:0] w_widx, w_ridx;
    logic                  w_unused_ok;

    assign w_aw_hs = axi.awvalid && r_awready;
    assign w_w_hs  = axi.wvalid && (r_w_state == W_DATA);
    assign w_ar_hs = axi.arvalid && r_arready;
    assign w_r_hs  = axi.rready && (r_r_state == R_DATA);

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .OB(OB)) u_wr_addr (
        .clk_core   (clk_core),
        .rst_n      (rst_n),
        .load       (w_aw_hs),
        .advance    (w_w_hs),
        .start_addr (axi.awaddr),
        .len        (axi.awlen),
        .size       (axi.awsize),
        .burst      (axi.awburst),
        .addr       (w_waddr),
        .beat       (w_wbeat),
        .last       (w_wlast_beat)
    );

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .OB(OB)) u_rd_addr (
        .clk_core   (clk_core),
        .rst_n      (rst_n),
        .load       (w_ar_hs),
        .advance    (w_r_hs),
        .start_addr (axi.araddr),
        .len        (axi.arlen),
        .size       (axi.arsize),
        .burst      (axi.arburst),
        .addr       (w_raddr),
        .beat       (w_rbeat),
        .last       (w_rlast_beat)
    );

    assign w_w_oor     = |w_waddr[ADDR_W-1:DEPTH_LOG2+OB];
    assign w_r_oor     = |w_raddr[ADDR_W-1:DEPTH_LOG2+OB];
    assign w_widx      = w_waddr[DEPTH_LOG2+OB-1:OB];
    assign w_ridx      = w_raddr[DEPTH_LOG2+OB-1:OB];
    assign w_wlast_err = w_w_hs && (axi.wlast != w_wlast_beat);
    assign w_unused_ok = ^{w_waddr[OB-1:0], w_raddr[OB-1:0], w_wbeat, w_rbeat};

    always_ff @(posedge clk_core) begin
        if (w_w_hs && !w_w_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.wstrb[b]) mem[w_widx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
        end else begin
            r_w_state <= w_w_next;
            r_awready <= (w_w_next == W_IDLE);
        end
    end

    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_w_next = W_RESP;
            W_RESP:  if (axi.bready) w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    always_comb begin
        axi.awready = r_awready;
        axi.wready  = (r_w_state == W_DATA);
        axi.bvalid  = (r_w_state == W_RESP);
        axi.bid     = r_wid;
        axi.bresp   = OKAY;
        if (r_w_state == W_RESP) begin
            if (r_w_decerr)      axi.bresp = DECERR;
            else if (r_w_slverr) axi.bresp = SLVERR;
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_wid           <= '0;
            r_w_decerr      <= 1'b0;
            r_w_slverr      <= 1'b0;
            r_wlast_err_cnt <= '0;
        end else begin
            if (w_aw_hs) begin
                r_wid      <= axi.awid;
                r_w_decerr <= 1'b0;
                r_w_slverr <= 1'b0;
            end else if (w_w_hs) begin
                if (w_w_oor)     r_w_decerr <= 1'b1;
                if (w_wlast_err) r_w_slverr <= 1'b1;
            end
            if (w_wlast_err && (r_wlast_err_cnt != 16'hFFFF))
                r_wlast_err_cnt <= r_wlast_err_cnt + 16'd1;
        end
    end

    assign wlast_err_cnt = r_wlast_err_cnt;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_r_state <= w_r_next;
            r_arready <= (w_r_next == R_IDLE);
        end
    end

    always_comb begin
        w_r_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_next = R_WAIT;
            R_WAIT:  if (r_lat_cnt == '0) w_r_next = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast_beat) w_r_next = R_IDLE;
            default: w_r_next = R_IDLE;
        endcase
    end

    // Combinational array read gives old data on a same-cycle write collision.
    always_comb begin
        axi.arready = r_arready;
        axi.rvalid  = (r_r_state == R_DATA);
        axi.rid     = r_rid;
        axi.rlast   = (r_r_state == R_DATA) && w_rlast_beat;
        axi.rresp   = OKAY;
        axi.rdata   = '0;
        if (r_r_state == R_DATA) begin
            if (w_r_oor) axi.rresp = DECERR;
            else         axi.rdata = mem[w_ridx];
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            r_rid     <= '0;
            r_lat_cnt <= '0;
        end else if (w_ar_hs) begin
            r_rid     <= axi.arid;
            r_lat_cnt <= LAT_W'(RD_LAT - 1);
        end else if ((r_r_state == R_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_slave_v2.sv
// ============================================================================
// Module : tb_axi_mem_slave_v2
// Scoreboard bench for axi_mem_slave_v2: directed bursts, queued expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_mem_slave_v2;
    import axi_mem_pkg::*;

    localparam int DATA_W     = 512;
    localparam int ID_W       = 16;
    localparam int ADDR_W     = 64;
    localparam int DEPTH_LOG2 = 12;
    localparam int RD_LAT     = 2;
    localparam int STRB_W     = DATA_W / 8;

    logic        clk_core = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] wlast_err_cnt;

    always #5 clk_core = ~clk_core;

    axi_mem_slave_v2_if #(.DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W)) axi ();

    axi_mem_slave_v2 #(
        .DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W),
        .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)
    ) dut (
        .clk_core      (clk_core),
        .rst_n         (rst_n),
        .axi           (axi),
        .wlast_err_cnt (wlast_err_cnt)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    logic   rtoggle = 1'b0;
    localparam logic [STRB_W-1:0] ALL_STRB = {STRB_W{1'b1}};

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no matching DUT activity", name);
    endtask

    task automatic exp_r(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                         input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    // rready: constantly high, or the 1,0,0 repeating pattern
    initial begin
        int cyc = 0;
        axi.rready = 1'b1;
        forever begin
            @(posedge clk_core); #1;
            cyc++;
            axi.rready = rtoggle ? ((cyc % 3) == 0) : 1'b1;
        end
    end

    // B monitor
    initial begin
        b_exp_t e;
        forever begin
            @(negedge clk_core);
            if (rst_n && axi.bvalid && axi.bready) begin
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    e = bq.pop_front();
                    chk("bresp", DATA_W'(axi.bresp), DATA_W'(e.resp));
                    chk("bid", DATA_W'(axi.bid), DATA_W'(e.id));
                end
            end
        end
    end

    // R monitor, including stability while stalled
    initial begin
        r_exp_t            e;
        logic              held;
        logic [DATA_W-1:0] held_data;
        logic              held_last;
        held = 1'b0; held_data = '0; held_last = 1'b0;
        forever begin
            @(negedge clk_core);
            if (!rst_n || !axi.rvalid) held = 1'b0;
            else begin
                if (held) begin
                    chk("rdata_hold", axi.rdata, held_data);
                    chk("rlast_hold", DATA_W'(axi.rlast), DATA_W'(held_last));
                end
                if (axi.rready) begin
                    held = 1'b0;
                    if (rq.size() == 0) fail_now("r_unexpected");
                    else begin
                        e = rq.pop_front();
                        chk("rdata", axi.rdata, e.data);
                        chk("rresp", DATA_W'(axi.rresp), DATA_W'(e.resp));
                        chk("rid", DATA_W'(axi.rid), DATA_W'(e.id));
                        chk("rlast", DATA_W'(axi.rlast), DATA_W'(e.last));
                    end
                end else begin
                    held = 1'b1; held_data = axi.rdata; held_last = axi.rlast;
                end
            end
        end
    end

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [DATA_W-1:0] base, input logic [STRB_W-1:0] strb,
                             input logic [15:0] wlast_mask, input logic [1:0] exp_resp);
        int t;
        bq.push_back('{id, exp_resp});
        axi.awid = id; axi.awaddr = addr; axi.awlen = len;
        axi.awsize = size; axi.awburst = burst; axi.awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk_core); t++; end while (!axi.awready && t < 50);
        if (!axi.awready) fail_now("aw_handshake");
        @(posedge clk_core); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.wdata = base + DATA_W'(i); axi.wstrb = strb;
            axi.wlast = wlast_mask[i]; axi.wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk_core); t++; end while (!axi.wready && t < 50);
            if (!axi.wready) fail_now("w_handshake");
            @(posedge clk_core); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        t = 0;
        while (bq.size() != 0 && t < 100) begin @(negedge clk_core); t++; end
        if (bq.size() != 0) begin fail_now("b_drain"); bq.delete(); end
        @(posedge clk_core); #1;
    endtask

    task automatic ar_issue(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int t;
        axi.arid = id; axi.araddr = addr; axi.arlen = len;
        axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk_core); t++; end while (!axi.arready && t < 50);
        if (!axi.arready) fail_now("ar_handshake");
        @(posedge clk_core); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input bit chk_lat);
        int t;
        ar_issue(id, addr, len, size, burst);
        if (chk_lat) begin
            t = 0;
            do begin @(negedge clk_core); t++; end while (!axi.rvalid && t < 50);
            chk("rd_latency", DATA_W'(t - 1), DATA_W'(RD_LAT));
        end
        t = 0;
        while (rq.size() != 0 && t < 300) begin @(negedge clk_core); t++; end
        if (rq.size() != 0) begin fail_now("r_drain"); rq.delete(); end
        @(posedge clk_core); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arvalid = 1'b0;

        repeat (3) @(posedge clk_core); #1;
        chk("reset_awready", DATA_W'(axi.awready), '0);
        chk("reset_arready", DATA_W'(axi.arready), '0);
        chk("reset_bvalid",  DATA_W'(axi.bvalid), '0);
        chk("reset_rvalid",  DATA_W'(axi.rvalid), '0);
        chk("reset_errcnt",  DATA_W'(wlast_err_cnt), '0);
        rst_n = 1'b1;

        // INCR write/read of 4 beats at 0x1000
        axi_write(16'h0011, 64'h1000, 8'd3, 3'd6, INCR, '0, ALL_STRB, 16'h0008, OKAY);
        for (int i = 0; i < 4; i++) exp_r(16'h0021, DATA_W'(i), OKAY, i == 3);
        axi_read(16'h0021, 64'h1000, 8'd3, 3'd6, INCR, 1'b1);

        // WRAP write at 0x1080 lands 0x20..0x23 at words 0x42,0x43,0x40,0x41
        axi_write(16'h0012, 64'h1080, 8'd3, 3'd6, WRAP, DATA_W'(32'h20), ALL_STRB, 16'h0008, OKAY);
        exp_r(16'h0022, DATA_W'(32'h22), OKAY, 1'b0);
        exp_r(16'h0022, DATA_W'(32'h23), OKAY, 1'b0);
        exp_r(16'h0022, DATA_W'(32'h20), OKAY, 1'b0);
        exp_r(16'h0022, DATA_W'(32'h21), OKAY, 1'b1);
        axi_read(16'h0022, 64'h1000, 8'd3, 3'd6, INCR, 1'b0);

        // narrow INCR stays in word 0x40; oversize is clamped to 64 bytes
        exp_r(16'h0023, DATA_W'(32'h22), OKAY, 1'b0);
        exp_r(16'h0023, DATA_W'(32'h22), OKAY, 1'b1);
        axi_read(16'h0023, 64'h1000, 8'd1, 3'd2, INCR, 1'b0);
        exp_r(16'h0024, DATA_W'(32'h22), OKAY, 1'b0);
        exp_r(16'h0024, DATA_W'(32'h23), OKAY, 1'b1);
        axi_read(16'h0024, 64'h1000, 8'd1, 3'd7, INCR, 1'b0);

        // out-of-range write and read
        axi_write(16'h0013, 64'd1 << (DEPTH_LOG2 + 6), 8'd0, 3'd6, INCR,
                  DATA_W'(32'hDEAD), ALL_STRB, 16'h0001, DECERR);
        exp_r(16'h0025, '0, OKAY, 1'b1);
        axi_read(16'h0025, 64'h0, 8'd0, 3'd6, INCR, 1'b0);
        exp_r(16'h0026, '0, DECERR, 1'b1);
        axi_read(16'h0026, 64'd1 << (DEPTH_LOG2 + 6), 8'd0, 3'd6, INCR, 1'b0);

        // early WLAST on beat 1, missing on beat 3
        axi_write(16'h0014, 64'h2000, 8'd3, 3'd6, INCR, DATA_W'(32'h30), ALL_STRB, 16'h0002, SLVERR);
        chk("wlast_err_cnt", DATA_W'(wlast_err_cnt), DATA_W'(2));
        for (int i = 0; i < 4; i++) exp_r(16'h0027, DATA_W'(32'h30 + i), OKAY, i == 3);
        axi_read(16'h0027, 64'h2000, 8'd3, 3'd6, INCR, 1'b0);

        // FIXED burst keeps only the final beat; then a 4-byte strobe write
        axi_write(16'h0015, 64'h4000, 8'd2, 3'd6, FIXED, DATA_W'(32'h70), ALL_STRB, 16'h0004, OKAY);
        exp_r(16'h0028, DATA_W'(32'h72), OKAY, 1'b0);
        exp_r(16'h0028, DATA_W'(32'h72), OKAY, 1'b1);
        axi_read(16'h0028, 64'h4000, 8'd1, 3'd6, FIXED, 1'b0);
        axi_write(16'h0016, 64'h4000, 8'd0, 3'd6, INCR, {DATA_W{1'b1}} - DATA_W'(1) + DATA_W'(1),
                  STRB_W'(4'hF), 16'h0001, OKAY);
        exp_r(16'h0029, DATA_W'(32'hFFFF_FFFF), OKAY, 1'b1);
        axi_read(16'h0029, 64'h4000, 8'd0, 3'd6, INCR, 1'b0);

        // 8-beat read under rready back-pressure
        axi_write(16'h0017, 64'h3000, 8'd7, 3'd6, INCR, DATA_W'(32'h50), ALL_STRB, 16'h0080, OKAY);
        rtoggle = 1'b1;
        for (int i = 0; i < 8; i++) exp_r(16'h002A, DATA_W'(32'h50 + i), OKAY, i == 7);
        axi_read(16'h002A, 64'h3000, 8'd7, 3'd6, INCR, 1'b0);

        // reset in the middle of a read burst
        for (int i = 0; i < 8; i++) exp_r(16'h002B, DATA_W'(32'h50 + i), OKAY, i == 7);
        ar_issue(16'h002B, 64'h3000, 8'd7, 3'd6, INCR);
        t = 0;
        while (rq.size() > 5 && t < 100) begin @(negedge clk_core); t++; end
        if (rq.size() > 5) fail_now("r_midburst");
        @(posedge clk_core); #1;
        rst_n = 1'b0;
        #1;
        chk("rvalid_in_reset",  DATA_W'(axi.rvalid), '0);
        chk("arready_in_reset", DATA_W'(axi.arready), '0);
        rq.delete();
        rtoggle = 1'b0;
        repeat (2) @(posedge clk_core); #1;
        rst_n = 1'b1;
        t = 0;
        do begin @(negedge clk_core); t++; end while (!axi.arready && t < 10);
        chk("arready_after_reset", DATA_W'(axi.arready), DATA_W'(1));
        chk("errcnt_after_reset", DATA_W'(wlast_err_cnt), '0);
        @(posedge clk_core); #1;

        // memory contents survive reset
        exp_r(16'h002C, DATA_W'(32'h53), OKAY, 1'b1);
        axi_read(16'h002C, 64'h30C0, 8'd0, 3'd6, INCR, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_mem_slave_v2.md
Name: axi_mem_slave_v2

Overview:
Parametrised single-port AXI4 slave memory model. It is the successor to the fixed 512-bit DDR slave BFM: data width, ID width, depth and read latency are configurable, and it adds FIXED/WRAP bursts, DECERR on out-of-range accesses, and WLAST checking. It sits on one DDR/AXI channel in the shell sim environment. Instances are generated per channel by the enclosing memory-model wrapper.

Parameters:
DATA_W, 512, data bus width in bits; power of two, 32 to 1024
ID_W, 16, AXI ID width
ADDR_W, 64, AXI address width
DEPTH_LOG2, 12, log2 of the number of DATA_W-bit memory words
RD_LAT, 2, cycles from AR handshake to first RVALID; must be at least 1

Ports:
clk_core  in  1  clock
rst_n  in  1  asynchronous active-low reset
awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address channel
awvalid in 1, awready out 1  write address handshake
wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data channel
wvalid in 1, wready out 1  write data handshake
bid/bresp  out  ID_W/2  write response
bvalid out 1, bready in 1  write response handshake
arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address channel
arvalid in 1, arready out 1  read address handshake
rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data channel
rvalid out 1, rready in 1  read data handshake
wlast_err_cnt  out  16  saturating count of WLAST protocol errors

Behaviour:
- Clock is clk_core. rst_n is asynchronous and active-low. Every output resets to 0. Both FSMs reset to IDLE.
- Memory array is zero-initialised at elaboration and is NOT cleared by reset. Asserting rst_n mid-burst abandons the burst; beats already written stay written.
- Word index = addr[DEPTH_LOG2+OB-1 : OB], where OB = log2(DATA_W/8). Address is out of range when any of addr[ADDR_W-1 : DEPTH_LOG2+OB] is nonzero; the check is done per beat.
- Beat address stepping, in burst order:
  - Beat 0 uses the AxADDR value as given.
  - FIXED (0): address never changes.
  - INCR (1): address += 2^size.
  - WRAP (2): boundary = (len+1)*2^size. Address is aligned down to the boundary and wraps within it. If len is not 1, 3, 7 or 15, the burst is treated as INCR.
  - Reserved (3): treated as INCR.
  - Size is clamped to OB.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size and burst; clear the beat counter; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes where wstrb=1, unless that beat is out of range (then nothing is written).
  - After exactly len+1 beats, go to W_RESP. Beat count, not WLAST, terminates the burst.
  - WLAST error: wlast=1 before the final beat, or wlast=0 on the final beat. Each error beat increments wlast_err_cnt (saturates at 16'hFFFF) and marks the burst SLVERR.
  - W_RESP: bvalid=1, bid = latched id. bresp priority: DECERR (3) if any beat was out of range, else SLVERR (2) on a WLAST error, else OKAY (0). Hold until bready; then go to W_IDLE.
  - awready is 0 outside W_IDLE, so only one write is outstanding.
- Read FSM: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the burst fields and load the latency counter with RD_LAT-1.
  - R_WAIT: decrement the counter. At 0 go to R_DATA, so the first rvalid is exactly RD_LAT cycles after the AR handshake.
  - R_DATA: rvalid=1. rdata = mem[word index] sampled combinationally from the current beat address. Out-of-range beats return all zeros with rresp=DECERR; other beats return OKAY. rid = latched id. rlast=1 on beat len.
  - On each handshake, advance the beat. After the rlast handshake, go to R_IDLE. rvalid, rdata and rlast stay stable while rready=0.
- Read/write collision: a W handshake and a read beat to the same word in the same cycle return the OLD data. The write is visible from the next cycle.
- Read and write paths are fully independent and may run concurrently.

Decomposition:
- Package axi_mem_pkg:
  - burst_t enum: FIXED, INCR, WRAP, RSVD.
  - resp constants: OKAY, SLVERR, DECERR.
  - function wrap_len_ok(len).
- Sub-module axi_burst_addr_gen: inputs are start addr, len, size, burst, a load strobe and an advance strobe. Outputs are the current beat address, beat index and a last flag. It is instantiated once for the write path and once for the read path.

Test Plan:
- DATA_W=512, RD_LAT=2: INCR write of awaddr=0x1000, len=3, all strobes, data = beat index, then read of the same burst -> bresp=0; rdata 0,1,2,3; first rvalid 2 cycles after the AR handshake; rlast on the 4th beat.
- WRAP write with addr=0x1080, len=3, size=6 -> beats land at 0x1080, 0x10C0, 0x1000, 0x1040; readback with INCR from 0x1000 returns beat order 2, 3, 0, 1.
- Write with awaddr = 1<<(DEPTH_LOG2+6) (out of range), len=0 -> bresp=3 and memory unchanged; read of the same address -> rdata=0, rresp=3.
- Write len=3 with wlast asserted on beat 1 -> 4 beats still accepted, bresp=2, wlast_err_cnt=2 (beat 1 early, beat 3 missing).
- Read burst len=7 with rready toggled 1,0,0,1,... -> no beat lost or duplicated; rdata stable while rready=0. Then rst_n pulsed mid-burst -> rvalid=0 immediately, arready=1 after reset release.
